// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter sharing one UART transmit byte channel
// among NREQ requesters, with an optional ASCII '0'+id tag before each message.
module uart_tx_arbiter #(
  parameter int NREQ      = 4,
  parameter bit PREFIX_EN = 1'b1,
  parameter int MAX_BURST = 64,
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              out_valid,
  output logic [7:0]        out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic [GW-1:0]     grant_id
);

  typedef enum logic [1:0] {IDLE, TAG, STREAM} state_t;

  state_t        state_reg, state_next;
  logic [GW-1:0] grant_reg, grant_next;
  logic [GW-1:0] rr_ptr_reg, rr_ptr_next;
  logic [BW-1:0] burst_cnt_reg, burst_cnt_next;

  logic [7:0]    data_arr [NREQ];
  logic          any_req;
  logic [GW-1:0] winner;
  logic          sel_valid;
  logic          sel_last;
  logic          xfer;
  logic          burst_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign data_arr[gi] = req_data[8*gi +: 8];
    end
  endgenerate

  generate
    if (MAX_BURST > 0) begin : g_burst_limit
      assign burst_hit = (burst_cnt_reg == BW'(MAX_BURST - 1));
    end else begin : g_burst_unlimited
      assign burst_hit = 1'b0;
    end
  endgenerate

  // Scan from rr_ptr+NREQ down to rr_ptr+1 so the nearest requester after rr_ptr wins last.
  always_comb begin
    int idx;
    idx     = 0;
    winner  = rr_ptr_reg;
    any_req = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req_valid[idx[GW-1:0]]) begin
        winner  = idx[GW-1:0];
        any_req = 1'b1;
      end
    end
  end

  assign sel_valid = req_valid[grant_reg];
  assign sel_last  = req_last[grant_reg];
  assign xfer      = (state_reg == STREAM) && sel_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      grant_reg     <= '0;
      rr_ptr_reg    <= GW'(NREQ - 1);
      burst_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      grant_reg     <= grant_next;
      rr_ptr_reg    <= rr_ptr_next;
      burst_cnt_reg <= burst_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    grant_next     = grant_reg;
    rr_ptr_next    = rr_ptr_reg;
    burst_cnt_next = burst_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          grant_next     = winner;
          rr_ptr_next    = winner;
          burst_cnt_next = '0;
          state_next     = PREFIX_EN ? TAG : STREAM;
        end
      end
      TAG: begin
        if (out_ready) state_next = STREAM;
      end
      STREAM: begin
        // Grant is held while the grantee idles; only a transfer can end it.
        if (xfer) begin
          if (sel_last || burst_hit) begin
            state_next     = IDLE;
            burst_cnt_next = '0;
          end else if (MAX_BURST > 0) begin
            burst_cnt_next = burst_cnt_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    req_ready = '0;
    case (state_reg)
      TAG: begin
        out_valid = 1'b1;
        out_data  = 8'h30 + 8'(grant_reg);
      end
      STREAM: begin
        out_valid            = sel_valid;
        out_data             = data_arr[grant_reg];
        req_ready[grant_reg] = out_ready;
      end
      default: begin
        out_valid = 1'b0;
      end
    endcase
  end

  assign busy     = (state_reg != IDLE);
  assign grant_id = grant_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queued requester sources feed the DUT and
// a scoreboard of expected output bytes is popped on every output handshake.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        busy;
  logic [1:0]  grant_id;

  uart_tx_arbiter #(.NREQ(4), .PREFIX_EN(1'b1), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks;
  int         errors;
  logic [8:0] src_q [4][$];
  logic [7:0] exp_q [$];
  logic [3:0] tx;
  logic       hold_v;
  logic [7:0] hold_d;
  logic       rdy_toggle;
  int         ncyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_src(input int i, input logic [7:0] d, input logic last);
    src_q[i].push_back({last, d});
  endtask

  task automatic push_exp(input logic [7:0] d);
    exp_q.push_back(d);
  endtask

  task automatic drive();
    logic [8:0] f;
    for (int i = 0; i < 4; i++) begin
      if (src_q[i].size() > 0) begin
        f = src_q[i][0];
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = f[7:0];
        req_last[i]        = f[8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  // One clock: check at negedge, then advance sources just after posedge.
  task automatic cycle();
    logic [7:0] e;
    @(negedge clk);
    if (rst) begin
      if (hold_v) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(hold_d));
      end
      chk("ready_mask", 32'(req_ready & ~(4'b0001 << grant_id)), 32'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_byte", 32'(out_data), 32'h100);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", 32'(out_data), 32'(e));
        end
      end
      hold_v = out_valid && !out_ready;
      hold_d = out_data;
    end else begin
      hold_v = 1'b0;
    end
    tx = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (tx[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    end
    if (rdy_toggle) out_ready = !out_ready;
    drive();
  endtask

  task automatic run_until_empty(input string tag, input int budget);
    ncyc = 0;
    while (exp_q.size() > 0 && ncyc < budget) begin
      cycle();
      ncyc++;
    end
    if (exp_q.size() > 0) chk({"timeout_", tag}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic idle_check(input string tag, input logic [1:0] g);
    @(negedge clk);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_grant_id"}, 32'(grant_id), 32'(g));
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    hold_v     = 1'b0;
    hold_d     = 8'h00;
    tx         = 4'h0;
    rdy_toggle = 1'b0;
    ncyc       = 0;
    rst        = 1'b0;
    out_ready  = 1'b1;
    req_valid  = 4'hF;
    req_data   = 32'h44332211;
    req_last   = 4'hF;

    // 1: reset held with every requester valid
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_grant_id", 32'(grant_id), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    drive();
    $display("T1 reset done");

    // 2: single message "Hi" from req1
    push_src(1, 8'h48, 1'b0);
    push_src(1, 8'h69, 1'b1);
    push_exp(8'h31); push_exp(8'h48); push_exp(8'h69);
    drive();
    run_until_empty("single", 20);
    idle_check("single", 2'd1);
    $display("T2 single message done");

    // 3: req0 and req2 contend; pointer sits at 1 so req2 goes first
    for (int k = 0; k < 3; k++) begin
      push_src(0, 8'h61 + 8'(k), 1'b1);
      push_src(2, 8'h78 + 8'(k), 1'b1);
    end
    for (int k = 0; k < 3; k++) begin
      push_exp(8'h32); push_exp(8'h78 + 8'(k));
      push_exp(8'h30); push_exp(8'h61 + 8'(k));
    end
    drive();
    run_until_empty("rr", 60);
    chk("rr_cycles", 32'(ncyc), 32'd18);
    idle_check("rr", 2'd0);
    $display("T3 round-robin done, cycles=%0d", ncyc);

    // 4: back-pressure on a 4-byte message from req3
    for (int k = 0; k < 4; k++) push_src(3, 8'hD0 + 8'(k), k == 3);
    push_exp(8'h33);
    for (int k = 0; k < 4; k++) push_exp(8'hD0 + 8'(k));
    rdy_toggle = 1'b1;
    drive();
    run_until_empty("bp", 40);
    rdy_toggle = 1'b0;
    out_ready  = 1'b1;
    idle_check("bp", 2'd3);
    $display("T4 back-pressure done");

    // 5a: burst limit of 4 with a lone requester
    for (int k = 0; k < 10; k++) push_src(0, 8'hA0 + 8'(k), k == 9);
    for (int k = 0; k < 10; k++) begin
      if (k % 4 == 0) push_exp(8'h30);
      push_exp(8'hA0 + 8'(k));
    end
    drive();
    run_until_empty("burst", 60);
    idle_check("burst", 2'd0);
    $display("T5a burst limit done");

    // 5b: req1 arrives after req0 is granted and slots in after the first burst
    for (int k = 0; k < 10; k++) push_src(0, 8'hC0 + 8'(k), k == 9);
    push_exp(8'h30);
    for (int k = 0; k < 4; k++) push_exp(8'hC0 + 8'(k));
    push_exp(8'h31); push_exp(8'h70); push_exp(8'h71);
    push_exp(8'h30);
    for (int k = 4; k < 8; k++) push_exp(8'hC0 + 8'(k));
    push_exp(8'h30); push_exp(8'hC8); push_exp(8'hC9);
    drive();
    cycle();
    push_src(1, 8'h70, 1'b0);
    push_src(1, 8'h71, 1'b1);
    drive();
    run_until_empty("interleave", 80);
    idle_check("interleave", 2'd0);
    $display("T5b interleave done");

    // 6: reset while req2 presents its third byte
    for (int k = 0; k < 4; k++) push_src(2, 8'hE0 + 8'(k), k == 3);
    push_exp(8'h32); push_exp(8'hE0); push_exp(8'hE1);
    drive();
    run_until_empty("mid", 20);
    rst       = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    chk("mid_byte3_valid", 32'(out_valid), 32'd1);
    chk("mid_byte3_data", 32'(out_data), 32'hE2);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_grant_id", 32'(grant_id), 32'd0);
    @(posedge clk);
    #1;
    src_q[2].delete();
    exp_q.delete();
    push_src(2, 8'h77, 1'b1);
    push_src(0, 8'h7A, 1'b1);
    push_exp(8'h30); push_exp(8'h7A); push_exp(8'h32); push_exp(8'h77);
    drive();
    @(posedge clk);
    #1;
    rst       = 1'b1;
    out_ready = 1'b1;
    run_until_empty("post_rst", 20);
    idle_check("post_rst", 2'd2);
    $display("T6 reset mid-stream done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
